// File: rtl/ssd_pkg.sv
// Shared seven-segment constants: bit positions and the hex digit glyph table.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs, element 0 is digit "0" (listed MSB-first for the packed array).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic seg_t seg_lookup(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg_lookup(i_nibble);

endmodule

// File: rtl/ssd_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous data update,
// leading-zero blanking and an anode guard interval against ghosting.
module ssd_mux
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 100000,
    parameter int GUARD      = 1,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic                  POL        = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF    = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{POL}};

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;

    logic                    w_tick;
    logic                    w_frame;
    logic [PW-1:0]           w_presc_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_pend_val_nxt;
    logic [NUM_DIGITS-1:0]   w_pend_dp_nxt;
    logic [4*NUM_DIGITS-1:0] w_disp_val_nxt;
    logic [NUM_DIGITS-1:0]   w_disp_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_blank;
    logic [6:0]              w_seg_ah;
    logic [6:0]              w_seg_on;
    logic [NUM_DIGITS-1:0]   w_an_ah;
    logic                    w_guard;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_frame     = w_tick && (r_idx == IDX_LAST);
    assign w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    assign w_idx_nxt   = !w_tick ? r_idx : ((r_idx == IDX_LAST) ? '0 : r_idx + 1'b1);

    // A load on the boundary cycle lands in pending and flows straight into display.
    assign w_pend_val_nxt = load ? value : r_pend_val;
    assign w_pend_dp_nxt  = load ? dp_in : r_pend_dp;
    assign w_disp_val_nxt = w_frame ? w_pend_val_nxt : r_disp_val;
    assign w_disp_dp_nxt  = w_frame ? w_pend_dp_nxt : r_disp_dp;

    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (w_disp_val_nxt[4*k +: 4] == 4'h0);
            w_lz[k]    = (BLANK_LZ != 0) && (k != 0) && w_zero_run;
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_blank  = 1'b0;
        w_an_ah  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == IW'(k)) begin
                w_nib      = w_disp_val_nxt[4*k +: 4];
                w_dp_sel   = w_disp_dp_nxt[k];
                w_blank    = w_lz[k];
                w_an_ah[k] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .i_nibble (w_nib),
        .o_seg    (w_seg_ah)
    );

    assign w_seg_on = w_blank ? 7'h00 : w_seg_ah;
    assign w_guard  = (int'(w_presc_nxt) < GUARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
            seg         <= SEG_OFF;
            dp          <= POL;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_idx       <= w_idx_nxt;
            r_pend_val  <= w_pend_val_nxt;
            r_pend_dp   <= w_pend_dp_nxt;
            r_disp_val  <= w_disp_val_nxt;
            r_disp_dp   <= w_disp_dp_nxt;
            seg         <= w_seg_on ^ SEG_OFF;
            dp          <= w_dp_sel ^ POL;
            an          <= w_guard ? AN_OFF : (w_an_ah ^ AN_OFF);
            frame_start <= w_tick && (w_idx_nxt == '0);
        end
    end

endmodule

// File: tb/tb_ssd_mux.sv
// Randomized and directed bench for ssd_mux (4-digit and 1-digit builds, DIV=4, GUARD=1).
module tb_ssd_mux;

    localparam int N    = 4;
    localparam int DV   = 4;
    localparam int FRM  = N * DV;
    localparam int W    = 23;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    logic [3:0]  value1;
    logic [0:0]  dp_in1;
    logic        load1;
    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  an1;
    logic        frame_start1;

    int n_checks = 0;
    int n_errors = 0;
    int e        = 0;
    int fs_cnt   = 0;

    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pend_dp, m_disp_dp;
    logic [3:0]  m1_pend, m1_disp;
    logic        m1_pend_dp, m1_disp_dp;
    logic [W-1:0] exp_q[$];

    logic [6:0] seg_hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    ssd_mux #(.NUM_DIGITS(N), .DIV(DV), .GUARD(1), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp_in       (dp_in),
        .load        (load),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    ssd_mux #(.NUM_DIGITS(1), .DIV(DV), .GUARD(1), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value1),
        .dp_in       (dp_in1),
        .load        (load1),
        .seg         (seg1),
        .dp          (dp1),
        .an          (an1),
        .frame_start (frame_start1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (e=%0d, t=%0t)", tag, obs, exp, e, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_pend = '0; m_disp = '0; m_pend_dp = '0; m_disp_dp = '0;
        m1_pend = '0; m1_disp = '0; m1_pend_dp = 1'b0; m1_disp_dp = 1'b0;
    endtask

    // Expected outputs after edge number e, straight from the display rules.
    function automatic logic [W-1:0] expected();
        int p, idx;
        logic [15:0] upper;
        logic [6:0]  s_on, s1;
        logic [3:0]  a;
        logic        d, f, a1, d1, f1;
        p     = e % DV;
        idx   = (e / DV) % N;
        upper = m_disp >> (4 * idx);
        s_on  = (idx > 0 && upper == 16'h0) ? 7'h00 : seg_hex[upper[3:0]];
        d     = ~m_disp_dp[idx];
        a     = (p < 1) ? 4'hF : ~(4'b0001 << idx);
        f     = (e > 0) && (e % FRM == 0);
        s1    = ~seg_hex[m1_disp];
        d1    = ~m1_disp_dp;
        a1    = (p < 1);
        f1    = (e > 0) && (p == 0);
        return {f1, a1, d1, s1, f, a, d, ~s_on};
    endfunction

    task automatic step();
        logic [W-1:0] ev;
        @(posedge clk);
        if (load)  begin m_pend = value;   m_pend_dp = dp_in;     end
        if (load1) begin m1_pend = value1; m1_pend_dp = dp_in1[0]; end
        e++;
        if (e % FRM == 0) begin m_disp = m_pend; m_disp_dp = m_pend_dp; end
        if (e % DV == 0)  begin m1_disp = m1_pend; m1_disp_dp = m1_pend_dp; end
        exp_q.push_back(expected());
        #1;
        ev = exp_q.pop_front();
        check("seg",  32'(seg),          32'(ev[6:0]));
        check("dp",   32'(dp),           32'(ev[7]));
        check("an",   32'(an),           32'(ev[11:8]));
        check("fs",   32'(frame_start),  32'(ev[12]));
        check("seg1", 32'(seg1),         32'(ev[19:13]));
        check("dp1",  32'(dp1),          32'(ev[20]));
        check("an1",  32'(an1),          32'(ev[21]));
        check("fs1",  32'(frame_start1), 32'(ev[22]));
        if (frame_start) fs_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic step_until_mod(input int m);
        for (int i = 0; i < FRM && (e % FRM) != m; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"},  32'(dp),  32'h1);
        check({tag, "_an"},  32'(an),  32'hF);
        check({tag, "_fs"},  32'(frame_start), 32'h0);
        check({tag, "_an1"}, 32'(an1), 32'h1);
        check({tag, "_seg1"}, 32'(seg1), 32'h7F);
    endtask

    initial begin
        rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0;
        value1 = '0; dp_in1 = '0; load1 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");
        #2 rst_n = 1'b1;

        // Both blank apart from "0" on digit 0 straight out of reset.
        run(4);
        value1 = 4'hF; load1 = 1'b1;
        step();
        load1 = 1'b0;

        do_load(16'h1234, 4'b0000);
        run(FRM);
        step_until_mod(1);
        check("d0_seg_4", 32'(seg), 32'h19);
        check("d0_an",    32'(an),  32'hE);
        step_until_mod(5);
        check("d1_seg_3", 32'(seg), 32'h30);
        check("d1_an",    32'(an),  32'hD);
        check("n1_seg_F", 32'(seg1), 32'h0E);

        do_load(16'h0007, 4'b0100);
        run(2 * FRM);

        // Mid-frame load at digit 2 must not disturb the current frame.
        step_until_mod(8);
        step();
        do_load(16'hAAAA, 4'b0000);
        run(FRM + 4);

        step_until_mod(2);
        do_load(16'h1111, 4'b0001);
        run(3);
        do_load(16'h2222, 4'b1000);
        fs_cnt = 0;
        run(4 * FRM);
        check("fs_per_64", 32'(fs_cnt), 32'd4);

        // Load landing exactly on the boundary edge shows up in the very next slot.
        step_until_mod(FRM - 1);
        do_load(16'h0B0C, 4'b0000);
        check("bnd_seg_C", 32'(seg), 32'h46);
        run(FRM);

        for (int i = 0; i < 300; i++) begin
            value1 = 4'($urandom_range(0, 15));
            dp_in1 = 1'($urandom_range(0, 1));
            load1  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) begin
                value = 16'($urandom() >> ($urandom_range(0, 3) * 4));
                dp_in = 4'($urandom_range(0, 15));
                load  = 1'b1;
            end
            step();
            load = 1'b0; load1 = 1'b0;
        end

        // Asynchronous reset in the middle of a slot.
        step_until_mod(6);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("hold");
        #2 rst_n = 1'b1;
        run(2 * FRM);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ssd_mux.md
SSD_MUX -- requirements
Module: ssd_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 SHALL have parameter DIV, default 100000: clock cycles per digit slot (>= GUARD+2).
REQ-003 SHALL have parameter GUARD, default 1: anode-off cycles at the start of each slot (anti-ghosting).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg, dp and an are driven active-low.
REQ-005 SHALL have parameter BLANK_LZ, default 1: 1 means leading-zero blanking is enabled.
REQ-006 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-010 SHALL have port load  input  1  capture strobe for value and dp_in.
REQ-011 SHALL have port seg  output  7  segments, bit 0 = a ... bit 6 = g.
REQ-012 SHALL have port dp  output  1  decimal-point segment.
REQ-013 SHALL have port an  output  NUM_DIGITS  digit enables (one-hot when active).
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Function
REQ-015 SHALL capture value and dp_in into a pending register on any cycle with load=1; the last load before a frame boundary wins.
REQ-016 SHALL copy pending into the display register only at the frame boundary (tick with index = NUM_DIGITS-1), so one frame never mixes old and new data.
REQ-017 SHALL count a prescaler 0..DIV-1 and wrap it to 0; tick = (prescaler == DIV-1).
REQ-018 SHALL increment the digit index mod NUM_DIGITS on tick, wrapping NUM_DIGITS-1 to 0.
REQ-019 SHALL register seg, dp, an and frame_start; they reflect the new index one cycle after the tick.
REQ-020 SHALL decode each nibble to active-high patterns 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bit 0 = a), then invert them when ACTIVE_LOW=1.
REQ-021 SHALL, when BLANK_LZ=1, blank seg for digit k>0 if nibbles k..NUM_DIGITS-1 of the display register are all zero; digit 0 is never blanked, and dp still follows dp_in.
REQ-022 SHALL hold an fully inactive for the first GUARD cycles of each slot (prescaler < GUARD after the registered update), then assert only an[index].
REQ-023 SHALL pulse frame_start for exactly one cycle, coincident with the first registered cycle of digit 0's slot.
REQ-024 SHALL, on load coincident with a frame boundary, first update pending, then copy that same new data into the display register in the same cycle.
REQ-025 SHALL, with NUM_DIGITS=1, keep index at 0 and make every tick a frame boundary.

Reset
REQ-026 SHALL asynchronously clear on rst_n=0: prescaler=0, index=0, pending=0, display=0, frame_start=0.
REQ-027 SHALL drive an all inactive and seg and dp all off (polarity per ACTIVE_LOW) during reset.
REQ-028 SHALL leave reset synchronously on the first clk edge after rst_n rises; reset mid-frame discards pending and display data.

Structure
REQ-029 SHALL place the 16-entry segment table and segment bit-index constants in shared package ssd_pkg.
REQ-030 SHALL instantiate one sub-module, seg7_decode (nibble in, active-high 7-bit pattern out, purely combinational).

Verification (NUM_DIGITS=4, DIV=4, GUARD=1, ACTIVE_LOW=1, BLANK_LZ=1 unless stated)
REQ-031 SHALL cover: reset, then load value=16'h1234 -> after the next frame boundary, each digit shows 4,3,2,1 at an=1110,1101,1011,0111; seg for digit 0 = ~7'h66; each an slot lasts 3 active + 1 guard cycles.
REQ-032 SHALL cover: load value=16'h0007, dp_in=4'b0100 -> digits 3 and 2 seg all ones (blanked), digit 2 dp=0, digit 1 blanked, digit 0 shows ~7'h07.
REQ-033 SHALL cover: load 16'hAAAA mid-frame at index 2 -> the rest of the frame still shows the old data, and the next frame shows all ~7'h77.
REQ-034 SHALL cover: load pulses with 16'h1111 then 16'h2222 in one frame -> the next frame shows only 2s; frame_start pulses once per 16 cycles.
REQ-035 SHALL cover: assert rst_n=0 mid-slot -> outputs inactive immediately, and after release the display shows blank digits 3..1 and "0" on digit 0.
REQ-036 SHALL cover: NUM_DIGITS=1, value=4'hF -> an toggles 0 for 3 cycles then 1 for 1 cycle, seg=~7'h71, and frame_start fires on every slot.
